serial_add_ctrl: RTL and testbench

Bit-serial addition sequencer that computes one WIDTH-bit sum using a single external 1-bit full adder. The block latches two operands and a carry-in, then presents them to the full adder one bit per clock, LSB first. It carries the full adder's carry-out into the next bit and assembles the result. It sits between a requesting unit and the shared `full_adder` cell.

---
 rtl/serial_add_ctrl_if.sv | 39 +++
 rtl/serial_add_ctrl.sv | 146 ++++++++++++++
 tb/tb_serial_add_ctrl.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_add_ctrl_if.sv
// Request/result bus between a requesting unit and serial_add_ctrl.
// The master side (requester) drives start/operands; the slave side
// (the sequencer) returns busy/done/sum/carry_out.
// Optional feature macro: SERIAL_ADD_OVF_EN adds the signed overflow flag.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
`ifdef SERIAL_ADD_OVF_EN
  logic             overflow;

  modport master (
    output start, op_a, op_b, c_in,
    input  busy, done, sum, carry_out, overflow
  );

  modport slave (
    input  start, op_a, op_b, c_in,
    output busy, done, sum, carry_out, overflow
  );
`else
  modport master (
    output start, op_a, op_b, c_in,
    input  busy, done, sum, carry_out
  );

  modport slave (
    input  start, op_a, op_b, c_in,
    output busy, done, sum, carry_out
  );
`endif
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial addition sequencer driving one shared external 1-bit full adder.
// Operands are latched on the accepting edge, then fed LSB first, one bit per
// clock; the carry-out is looped back through cy and the sum bits are shifted
// into acc from the top. Result and final carry are registered and held.
// Optional feature macro: SERIAL_ADD_OVF_EN (signed overflow flag on the bus).
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  serial_add_ctrl_if.slave    req,
  output logic                fa_a,
  output logic                fa_b,
  output logic                fa_cin,
  input  logic                fa_sum,
  input  logic                fa_cout
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic             cy;
  logic [CNT_W-1:0] cnt;
  logic             last_bit;

  assign last_bit = (cnt == CNT_LAST);

  // State register plus busy/done, registered from the next state so they
  // line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      req.busy <= 1'b0;
      req.done <= 1'b0;
    end else begin
      state    <= state_next;
      req.busy <= (state_next != IDLE);
      req.done <= (state_next == DONE);
    end
  end

  // Next-state logic: start is only looked at in IDLE; DONE lasts one cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req.start) begin
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        if (last_bit) begin
          state_next = DONE;
        end else begin
          state_next = RUN;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Full-adder drive: current LSBs and loop carry in RUN, quiet otherwise.
  always_comb begin
    fa_a   = 1'b0;
    fa_b   = 1'b0;
    fa_cin = 1'b0;
    if (state == RUN) begin
      fa_a   = a_sh[0];
      fa_b   = b_sh[0];
      fa_cin = cy;
    end else begin
      fa_a   = 1'b0;
      fa_b   = 1'b0;
      fa_cin = 1'b0;
    end
  end

  // Datapath: latch on accept, shift one bit per RUN cycle, publish result
  // on the final bit. The full adder is combinational, so its return is
  // captured in the same cycle the operand bits are presented.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh          <= '0;
      b_sh          <= '0;
      acc           <= '0;
      cy            <= 1'b0;
      cnt           <= '0;
      req.sum       <= '0;
      req.carry_out <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      req.overflow  <= 1'b0;
`else
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req.start) begin
            a_sh <= req.op_a;
            b_sh <= req.op_b;
            cy   <= req.c_in;
            cnt  <= '0;
            acc  <= '0;
          end
        end
        RUN: begin
          acc  <= {fa_sum, acc[WIDTH-1:1]};
          a_sh <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh <= {1'b0, b_sh[WIDTH-1:1]};
          cy   <= fa_cout;
          cnt  <= cnt + CNT_ONE;
          if (last_bit) begin
            req.sum       <= {fa_sum, acc[WIDTH-1:1]};
            req.carry_out <= fa_cout;
`ifdef SERIAL_ADD_OVF_EN
            // cy holds the carry into the MSB at this point.
            req.overflow  <= cy ^ fa_cout;
`else
`endif
          end
        end
        DONE: begin
          cnt <= '0;
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl at WIDTH=8 with a
// combinational full adder attached. Overflow checks are compiled in only
// when SERIAL_ADD_OVF_EN is defined.
module tb_serial_add_ctrl;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst;
  logic fa_a, fa_b, fa_cin, fa_sum, fa_cout;

  int vectors     = 0;
  int miscompares = 0;

  serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (bus),
    .fa_a    (fa_a),
    .fa_b    (fa_b),
    .fa_cin  (fa_cin),
    .fa_sum  (fa_sum),
    .fa_cout (fa_cout)
  );

  // External full adder cell
  assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
  assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

  always #5 clk = ~clk;

  // Stimulus only: one add. lat counts edges from the accept edge (inclusive)
  // to the first sample with done high; dwidth counts cycles done stays high.
  // seen_a/seen_b collect fa_a/fa_b over the eight RUN cycles.
  task automatic do_add(input logic [7:0] a, input logic [7:0] b, input logic c,
                        output int lat, output int dwidth,
                        output logic [7:0] seen_a, output logic [7:0] seen_b);
    @(negedge clk);
    bus.start = 1'b1; bus.op_a = a; bus.op_b = b; bus.c_in = c;
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.op_a = ~a; bus.op_b = ~b; bus.c_in = ~c;
    lat = 0; dwidth = 0; seen_a = 8'h00; seen_b = 8'h00;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k <= 8) begin
        seen_a[k-1] = fa_a;
        seen_b[k-1] = fa_b;
      end
      if (bus.done) begin
        if (lat == 0) lat = k;
        dwidth++;
      end else if (lat != 0) begin
        break;
      end
    end
  endtask

  task automatic test_reset;
    bus.start = 1'b0; bus.op_a = 8'h00; bus.op_b = 8'h00; bus.c_in = 1'b0;
    rst = 1'b1;
    #2;
    vectors++;
    if ({bus.busy, bus.done, bus.carry_out, fa_a, fa_b, fa_cin} !== 6'b000000) begin
      miscompares++;
      $display("FAIL reset_ctrl: got busy/done/cout/fa=%b required 000000",
               {bus.busy, bus.done, bus.carry_out, fa_a, fa_b, fa_cin});
    end
    vectors++;
    if (bus.sum !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_sum: got %h required 00", bus.sum);
    end
`ifdef SERIAL_ADD_OVF_EN
    vectors++;
    if (bus.overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ovf: got %b required 0", bus.overflow);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_zero_add;
    int lat, dw;
    logic [7:0] sa, sb;
    do_add(8'h00, 8'h00, 1'b0, lat, dw, sa, sb);
    vectors++;
    if (bus.sum !== 8'h00 || bus.carry_out !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_result: got %h/%b required 00/0", bus.sum, bus.carry_out);
    end
    // Accept edge counted as edge 1: done first seen after the 9th edge.
    vectors++;
    if (lat !== 9) begin
      miscompares++;
      $display("FAIL zero_latency: got %0d required 9", lat);
    end
    vectors++;
    if (dw !== 1) begin
      miscompares++;
      $display("FAIL zero_done_width: got %0d required 1", dw);
    end
  endtask

  task automatic test_carry_chain;
    int lat, dw;
    logic [7:0] sa, sb;
    do_add(8'hFF, 8'h01, 1'b0, lat, dw, sa, sb);
    vectors++;
    if (bus.sum !== 8'h00 || bus.carry_out !== 1'b1) begin
      miscompares++;
      $display("FAIL chain_result: got %h/%b required 00/1", bus.sum, bus.carry_out);
    end
    vectors++;
    if (sa !== 8'hFF || sb !== 8'h01) begin
      miscompares++;
      $display("FAIL chain_fa_bits: got a=%h b=%h required a=ff b=01", sa, sb);
    end
`ifdef SERIAL_ADD_OVF_EN
    vectors++;
    if (bus.overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL chain_ovf: got %b required 0", bus.overflow);
    end
`endif
  endtask

  task automatic test_overflow;
    int lat, dw;
    logic [7:0] sa, sb;
    do_add(8'h7F, 8'h01, 1'b0, lat, dw, sa, sb);
    vectors++;
    if (bus.sum !== 8'h80 || bus.carry_out !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_result: got %h/%b required 80/0", bus.sum, bus.carry_out);
    end
    vectors++;
    if (sa !== 8'h7F) begin
      miscompares++;
      $display("FAIL ovf_fa_bits: got a=%h required 7f", sa);
    end
`ifdef SERIAL_ADD_OVF_EN
    vectors++;
    if (bus.overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_flag: got %b required 1", bus.overflow);
    end
`endif
  endtask

  task automatic test_ignored_start;
    int lat;
    lat = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.op_a = 8'hA5; bus.op_b = 8'h5A; bus.c_in = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.op_a = 8'h00; bus.op_b = 8'h00; bus.c_in = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (bus.done) begin
        // Pulse start during DONE with other operands.
        lat = k;
        bus.start = 1'b1; bus.op_a = 8'h33; bus.op_b = 8'h44; bus.c_in = 1'b0;
        break;
      end else if (k == 3) begin
        // Pulse start during RUN with other operands.
        bus.start = 1'b1; bus.op_a = 8'h11; bus.op_b = 8'h22; bus.c_in = 1'b0;
      end else begin
        bus.start = 1'b0;
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL done_start_ignored: got busy=%b required 0", bus.busy);
    end
    @(negedge clk);
    vectors++;
    if (lat !== 9) begin
      miscompares++;
      $display("FAIL ign_latency: got %0d required 9", lat);
    end
    vectors++;
    if (bus.sum !== 8'h00 || bus.carry_out !== 1'b1 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL ign_result: got %h/%b busy=%b required 00/1 busy=0",
               bus.sum, bus.carry_out, bus.busy);
    end
  endtask

  task automatic test_back_to_back;
    int first_idle, reaccept, got_done;
    first_idle = 0; reaccept = 0; got_done = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.op_a = 8'h0F; bus.op_b = 8'h01; bus.c_in = 1'b0;
    @(posedge clk);
    #1;
    bus.op_a = 8'h20; bus.op_b = 8'h03;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (!bus.busy && first_idle == 0) begin
        first_idle = k;
      end else if (bus.busy && first_idle != 0) begin
        reaccept = k - 1;
        bus.start = 1'b0;
        break;
      end
    end
    bus.start = 1'b0;
    vectors++;
    if (reaccept !== 10) begin
      miscompares++;
      $display("FAIL b2b_reaccept_edge: got E%0d required E10", reaccept);
    end
    vectors++;
    if (bus.sum !== 8'h10 || bus.carry_out !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_first: got %h/%b required 10/0", bus.sum, bus.carry_out);
    end
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.done) begin
        got_done = 1;
        break;
      end
    end
    vectors++;
    if (got_done !== 1 || bus.sum !== 8'h23 || bus.carry_out !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_second: got done=%0d %h/%b required done=1 23/0",
               got_done, bus.sum, bus.carry_out);
    end
  endtask

  task automatic test_reset_mid_run;
    int lat, dw, done_seen;
    logic [7:0] sa, sb;
    done_seen = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.op_a = 8'h55; bus.op_b = 8'h11; bus.c_in = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    // Bits 0..4 processed at E1..E5.
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if ({bus.busy, bus.done, bus.carry_out, fa_a, fa_b, fa_cin} !== 6'b000000 ||
        bus.sum !== 8'h00) begin
      miscompares++;
      $display("FAIL midrst_clear: got ctrl=%b sum=%h required 000000 sum=00",
               {bus.busy, bus.done, bus.carry_out, fa_a, fa_b, fa_cin}, bus.sum);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (bus.done || bus.busy) done_seen++;
    end
    vectors++;
    if (done_seen !== 0) begin
      miscompares++;
      $display("FAIL midrst_no_done: got %0d active cycles required 0", done_seen);
    end
    do_add(8'h12, 8'h34, 1'b0, lat, dw, sa, sb);
    vectors++;
    if (bus.sum !== 8'h46 || bus.carry_out !== 1'b0 || lat !== 9) begin
      miscompares++;
      $display("FAIL midrst_next_add: got %h/%b lat=%0d required 46/0 lat=9",
               bus.sum, bus.carry_out, lat);
    end
  endtask

  initial begin
    test_reset();
    test_zero_add();
    test_carry_chain();
    test_overflow();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
